// File: rtl/shift_register_pkg.sv
// Operation codes shared by the universal shift register and its per-bit cells.
// The helper classifies the modes that advance the shift counter.
package shift_register_pkg;

    localparam logic [2:0] MODE_HOLD  = 3'd0;
    localparam logic [2:0] MODE_LOAD  = 3'd1;
    localparam logic [2:0] MODE_SHL   = 3'd2;
    localparam logic [2:0] MODE_SHR   = 3'd3;
    localparam logic [2:0] MODE_ROL   = 3'd4;
    localparam logic [2:0] MODE_ROR   = 3'd5;
    localparam logic [2:0] MODE_ASR   = 3'd6;
    localparam logic [2:0] MODE_CLEAR = 3'd7;

    function automatic logic is_shift_mode(input logic [2:0] mode);
        return (mode >= MODE_SHL) && (mode <= MODE_ASR);
    endfunction

endpackage

// File: rtl/shift_register_univ_cell.sv
// One register bit: picks its next value from the parallel input, the neighbour
// on the MSB side (right-moving ops), the neighbour on the LSB side (left-moving ops) or zero.
module shift_register_univ_cell
    import shift_register_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_en,
    input  logic [2:0] i_mode,
    input  logic       i_left,
    input  logic       i_right,
    input  logic       i_par,
    output logic       o_q
);

    logic r_q;
    logic w_next;

    always_comb begin
        w_next = r_q;
        case (i_mode)
            MODE_LOAD:                    w_next = i_par;
            MODE_SHL, MODE_ROL:           w_next = i_right;
            MODE_SHR, MODE_ROR, MODE_ASR: w_next = i_left;
            MODE_CLEAR:                   w_next = 1'b0;
            default:                      w_next = r_q;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_q <= 1'b0;
        end else if (i_en) begin
            r_q <= w_next;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/shift_register_univ.sv
// Parametrised universal shift register with a saturating shift counter and a
// one-cycle frame-done pulse after WIDTH shift/rotate operations.
module shift_register_univ
    import shift_register_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic [2:0]       i_mode,
    input  logic             i_ser_in_l,
    input  logic             i_ser_in_r,
    input  logic [WIDTH-1:0] i_par_in,
    output logic [WIDTH-1:0] o_par_out,
    output logic             o_ser_out_l,
    output logic             o_ser_out_r,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_done
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);

    logic [WIDTH-1:0] w_q;
    logic             w_msb_feed;   // what enters bit WIDTH-1 on right-moving ops
    logic             w_lsb_feed;   // what enters bit 0 on left-moving ops
    logic [CNT_W-1:0] r_cnt;
    logic             r_done;

    always_comb begin
        w_lsb_feed = (i_mode == MODE_ROL) ? w_q[WIDTH-1] : i_ser_in_l;
        case (i_mode)
            MODE_ROR: w_msb_feed = w_q[0];
            MODE_ASR: w_msb_feed = w_q[WIDTH-1];
            default:  w_msb_feed = i_ser_in_r;
        endcase
    end

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            logic w_left;
            logic w_right;

            if (gi == WIDTH - 1) begin : g_msb
                assign w_left = w_msb_feed;
            end else begin : g_mid_l
                assign w_left = w_q[gi+1];
            end

            if (gi == 0) begin : g_lsb
                assign w_right = w_lsb_feed;
            end else begin : g_mid_r
                assign w_right = w_q[gi-1];
            end

            shift_register_univ_cell u_cell (
                .i_clk   (i_clk),
                .i_rst   (i_rst),
                .i_en    (i_en),
                .i_mode  (i_mode),
                .i_left  (w_left),
                .i_right (w_right),
                .i_par   (i_par_in[gi]),
                .o_q     (w_q[gi])
            );
        end
    endgenerate

    // Counter saturates at WIDTH; done fires only on the WIDTH-1 -> WIDTH step.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt  <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_en) begin
                if ((i_mode == MODE_LOAD) || (i_mode == MODE_CLEAR)) begin
                    r_cnt <= '0;
                end else if (is_shift_mode(i_mode) && (r_cnt != CNT_MAX)) begin
                    r_cnt  <= r_cnt + 1'b1;
                    r_done <= (r_cnt == CNT_MAX - 1'b1);
                end
            end
        end
    end

    assign o_par_out   = w_q;
    assign o_ser_out_l = w_q[WIDTH-1];
    assign o_ser_out_r = w_q[0];
    assign o_cnt       = r_cnt;
    assign o_done      = r_done;

endmodule

// File: tb/tb_shift_register_univ.sv
// Drives a WIDTH=8 and a WIDTH=2 instance with the same stimulus and compares
// both against an arithmetic reference model after every clock edge.
module tb_shift_register_univ;

    logic       clk;
    logic       rst;
    logic       en;
    logic [2:0] mode;
    logic       sl;
    logic       sr;
    logic [7:0] par;

    logic [7:0] par_out8;
    logic       ser_l8, ser_r8, done8;
    logic [3:0] cnt8;
    logic [1:0] par_out2;
    logic       ser_l2, ser_r2, done2;
    logic [1:0] cnt2;

    logic [7:0] m8;
    logic [1:0] m2;
    int         c8, c2;
    logic       d8, d2;

    int n_vec = 0;
    int n_err = 0;

    shift_register_univ #(.WIDTH(8)) u_dut8 (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_en        (en),
        .i_mode      (mode),
        .i_ser_in_l  (sl),
        .i_ser_in_r  (sr),
        .i_par_in    (par),
        .o_par_out   (par_out8),
        .o_ser_out_l (ser_l8),
        .o_ser_out_r (ser_r8),
        .o_cnt       (cnt8),
        .o_done      (done8)
    );

    shift_register_univ #(.WIDTH(2)) u_dut2 (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_en        (en),
        .i_mode      (mode),
        .i_ser_in_l  (sl),
        .i_ser_in_r  (sr),
        .i_par_in    (par[1:0]),
        .o_par_out   (par_out2),
        .o_ser_out_l (ser_l2),
        .o_ser_out_r (ser_r2),
        .o_cnt       (cnt2),
        .o_done      (done2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, want $finish before 2 ms");
        $fatal(1, "watchdog expired");
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Register contents as integers: shifts are multiply/divide by two, masked to w bits.
    function automatic logic [31:0] ref_next(input int w, input logic [31:0] r, input logic [2:0] md,
                                             input logic [31:0] p, input logic s_l, input logic s_r);
        logic [31:0] mask;
        logic [31:0] top;
        mask = (32'd1 << w) - 32'd1;
        top  = 32'd1 << (w - 1);
        case (md)
            3'd0:    return r;
            3'd1:    return p & mask;
            3'd2:    return ((r * 2) + {31'd0, s_l}) & mask;
            3'd3:    return (r / 2) + (s_r ? top : 32'd0);
            3'd4:    return ((r * 2) & mask) + (((r & top) != 0) ? 32'd1 : 32'd0);
            3'd5:    return (r / 2) + (r[0] ? top : 32'd0);
            3'd6:    return (r / 2) + (((r & top) != 0) ? top : 32'd0);
            default: return 32'd0;
        endcase
    endfunction

    task automatic ref_step(input int w, input logic [31:0] r_in, input int c_in,
                            input logic t_rst, input logic t_en, input logic [2:0] t_mode,
                            input logic [31:0] t_par, input logic t_sl, input logic t_sr,
                            output logic [31:0] r_out, output int c_out, output logic d_out);
        r_out = r_in;
        c_out = c_in;
        d_out = 1'b0;
        if (t_rst) begin
            r_out = 32'd0;
            c_out = 0;
        end else if (t_en) begin
            r_out = ref_next(w, r_in, t_mode, t_par, t_sl, t_sr);
            if (t_mode == 3'd1 || t_mode == 3'd7) begin
                c_out = 0;
            end else if (t_mode != 3'd0 && c_in < w) begin
                c_out = c_in + 1;
                d_out = (c_out == w);
            end
        end
    endtask

    task automatic step(input logic t_rst, input logic t_en, input logic [2:0] t_mode,
                        input logic [7:0] t_par, input logic t_sl, input logic t_sr);
        logic [31:0] r_tmp;
        rst  = t_rst;
        en   = t_en;
        mode = t_mode;
        par  = t_par;
        sl   = t_sl;
        sr   = t_sr;
        @(posedge clk);
        #1;
        ref_step(8, 32'(m8), c8, t_rst, t_en, t_mode, 32'(t_par), t_sl, t_sr, r_tmp, c8, d8);
        m8 = r_tmp[7:0];
        ref_step(2, 32'(m2), c2, t_rst, t_en, t_mode, 32'(t_par), t_sl, t_sr, r_tmp, c2, d2);
        m2 = r_tmp[1:0];
        check_val("par8",  32'(par_out8), 32'(m8));
        check_val("cnt8",  32'(cnt8),     32'(c8));
        check_val("done8", 32'(done8),    32'(d8));
        check_val("serl8", 32'(ser_l8),   32'(m8[7]));
        check_val("serr8", 32'(ser_r8),   32'(m8[0]));
        check_val("par2",  32'(par_out2), 32'(m2));
        check_val("cnt2",  32'(cnt2),     32'(c2));
        check_val("done2", 32'(done2),    32'(d2));
        check_val("serl2", 32'(ser_l2),   32'(m2[1]));
        check_val("serr2", 32'(ser_r2),   32'(m2[0]));
    endtask

    initial begin
        logic [7:0] frame_bits;
        m8 = '0; m2 = '0; c8 = 0; c2 = 0; d8 = 1'b0; d2 = 1'b0;

        // Reset beats an enabled LOAD of 0xFF
        step(1'b1, 1'b1, 3'd1, 8'hFF, 1'b0, 1'b0);
        step(1'b1, 1'b1, 3'd1, 8'hFF, 1'b0, 1'b0);
        check_val("rst_par", 32'(par_out8), 32'h00);
        check_val("rst_cnt", 32'(cnt8), 32'd0);
        step(1'b0, 1'b1, 3'd1, 8'hA5, 1'b0, 1'b0);
        check_val("load_a5", 32'(par_out8), 32'hA5);

        step(1'b0, 1'b1, 3'd2, 8'h00, 1'b1, 1'b0);
        check_val("shl_4b", 32'(par_out8), 32'h4B);
        step(1'b0, 1'b1, 3'd1, 8'hA5, 1'b0, 1'b0);
        step(1'b0, 1'b1, 3'd3, 8'h00, 1'b0, 1'b0);
        check_val("shr_52", 32'(par_out8), 32'h52);
        step(1'b0, 1'b1, 3'd1, 8'hA5, 1'b0, 1'b0);
        step(1'b0, 1'b1, 3'd4, 8'h00, 1'b0, 1'b0);
        check_val("rol_4b", 32'(par_out8), 32'h4B);
        step(1'b0, 1'b1, 3'd1, 8'hA5, 1'b0, 1'b0);
        step(1'b0, 1'b1, 3'd5, 8'h00, 1'b0, 1'b0);
        check_val("ror_d2", 32'(par_out8), 32'hD2);
        step(1'b0, 1'b1, 3'd1, 8'h85, 1'b0, 1'b0);
        step(1'b0, 1'b1, 3'd6, 8'h00, 1'b0, 1'b0);
        check_val("asr_c2", 32'(par_out8), 32'hC2);

        // Frame: serial LSB-first readout of 0x81, then one saturating extra shift
        frame_bits = 8'b1000_0001;
        step(1'b0, 1'b1, 3'd1, 8'h81, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            check_val("frame_ser", 32'(ser_r8), 32'(frame_bits[i]));
            step(1'b0, 1'b1, 3'd3, 8'h00, 1'b0, 1'b0);
        end
        check_val("frame_done", 32'(done8), 32'd1);
        check_val("frame_cnt", 32'(cnt8), 32'd8);
        step(1'b0, 1'b1, 3'd3, 8'h00, 1'b0, 1'b0);
        check_val("sat_cnt", 32'(cnt8), 32'd8);
        check_val("sat_done", 32'(done8), 32'd0);

        // Enable gating with alternating i_en
        step(1'b0, 1'b1, 3'd1, 8'h3C, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            step(1'b0, logic'(i % 2), 3'd2, 8'h00, 1'($urandom), 1'b0);
        end
        check_val("gate_done", 32'(done8), 32'd1);

        // CLEAR after 5 shifts
        step(1'b0, 1'b1, 3'd1, 8'h5A, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 3'd4, 8'h00, 1'b0, 1'b0);
        step(1'b0, 1'b1, 3'd7, 8'h00, 1'b0, 1'b0);
        check_val("clr_par", 32'(par_out8), 32'd0);
        check_val("clr_cnt", 32'(cnt8), 32'd0);

        // LOAD where the 8th shift would have been
        step(1'b0, 1'b1, 3'd1, 8'h77, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 3'd5, 8'h00, 1'b0, 1'b0);
        step(1'b0, 1'b1, 3'd1, 8'hE1, 1'b0, 1'b0);
        check_val("ldwin_done", 32'(done8), 32'd0);
        check_val("ldwin_cnt", 32'(cnt8), 32'd0);

        // WIDTH=2 instance: LOAD 0b10, ROL twice
        step(1'b0, 1'b1, 3'd1, 8'h02, 1'b0, 1'b0);
        step(1'b0, 1'b1, 3'd4, 8'h00, 1'b0, 1'b0);
        check_val("w2_rol1", 32'(par_out2), 32'h1);
        step(1'b0, 1'b1, 3'd4, 8'h00, 1'b0, 1'b0);
        check_val("w2_rol2", 32'(par_out2), 32'h2);
        check_val("w2_done", 32'(done2), 32'd1);

        // Randomized traffic, weighted toward shifts so frames complete
        for (int i = 0; i < 400; i++) begin
            logic [2:0] r_mode;
            logic       r_rst;
            logic       r_en;
            r_mode = ($urandom_range(0, 9) < 7) ? 3'($urandom_range(2, 6)) : 3'($urandom_range(0, 7));
            r_rst  = ($urandom_range(0, 49) == 0);
            r_en   = ($urandom_range(0, 9) != 0);
            step(r_rst, r_en, r_mode, 8'($urandom), 1'($urandom), 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/shift_register_univ.md
# shift_register_univ

Parametrised universal shift register, the successor to the fixed 8-bit load/shift-left register. It supports these operations:
- parallel load
- logical shift left/right
- rotate left/right
- arithmetic shift right
- synchronous clear

A shift counter tracks shifts since the last load or clear and flags frame completion after WIDTH shifts. It serves as the general serialiser/deserialiser and bit-manipulation stage for the training-course datapath projects.

## Interface
Parameters:
- WIDTH, 8, register width in bits; legal range ≥ 2.
- CNT_W, $clog2(WIDTH+1), counter width; derived, not overridden.

Ports:
- i_clk  input  1  clock; all state updates on the rising edge.
- i_rst  input  1  reset; synchronous, active-high.
- i_en  input  1  operation enable; low = hold everything.
- i_mode  input  3  operation select (encoding in Operation).
- i_ser_in_l  input  1  serial bit entering bit 0 on SHL.
- i_ser_in_r  input  1  serial bit entering bit WIDTH-1 on SHR.
- i_par_in  input  WIDTH  parallel load data.
- o_par_out  output  WIDTH  register contents.
- o_ser_out_l  output  1  = o_par_out[WIDTH-1].
- o_ser_out_r  output  1  = o_par_out[0].
- o_cnt  output  CNT_W  shift/rotate operations since last LOAD/CLEAR/reset; saturates at WIDTH.
- o_done  output  1  one-cycle pulse when o_cnt reaches WIDTH.

## Operation
Mode encoding and next-state of register R (applies only when i_en=1):
- 0 HOLD: R unchanged.
- 1 LOAD: R ← i_par_in.
- 2 SHL: R ← {R[WIDTH-2:0], i_ser_in_l}.
- 3 SHR: R ← {i_ser_in_r, R[WIDTH-1:1]}.
- 4 ROL: R ← {R[WIDTH-2:0], R[WIDTH-1]}.
- 5 ROR: R ← {R[0], R[WIDTH-1:1]}.
- 6 ASR: R ← {R[WIDTH-1], R[WIDTH-1:1]}.
- 7 CLEAR: R ← 0.

Counter:
- LOAD or CLEAR sets o_cnt ← 0.
- Modes 2–6 set o_cnt ← min(o_cnt+1, WIDTH).
- HOLD leaves o_cnt unchanged.

o_done:
- Registered; o_done ← 1 for exactly the cycle after an operation that moves o_cnt from WIDTH-1 to WIDTH. Otherwise 0.
- Further shifts at saturation do not re-assert o_done.
- The register keeps shifting/rotating normally at saturation; only the counter saturates.

i_en=0: R, o_cnt held; o_done ← 0.

Reset (i_rst=1 at a rising edge): R ← 0, o_cnt ← 0, o_done ← 0. Reset has priority over i_en and all modes. A reset mid-frame discards the frame; no o_done is produced for it.

o_ser_out_l and o_ser_out_r are combinational taps of R; no extra register.

## Timing
- All operations take effect at the rising edge where i_en=1. o_par_out reflects the result one cycle after the inputs are sampled.
- o_done asserts on the same edge at which o_par_out shows the WIDTH-th shifted value.
- LOAD followed by WIDTH consecutive enabled shift cycles: o_done high in the cycle after the last shift. Shift cycles may be interleaved with HOLD or i_en=0 cycles without affecting the count.
- A LOAD in the same cycle the counter would reach WIDTH: LOAD wins. o_cnt ← 0, no o_done.
- Throughput: one operation per clock, no stalls or backpressure.

## Structure
- Shared package shift_register_pkg holds the 3-bit mode localparams:
  - MODE_HOLD, MODE_LOAD, MODE_SHL, MODE_SHR, MODE_ROL, MODE_ROR, MODE_ASR, MODE_CLEAR.
- One sub-module is natural: shift_register_univ_cell, a per-bit flop with its next-value mux.
  - Inputs: own bit, left neighbour, right neighbour, par bit, mode, en, rst.
  - Instantiated WIDTH times in a generate loop. Edge bits take serial-in, wrap or sign inputs.
- Counter and o_done logic live in the top module.

## Test plan
All scenarios use WIDTH=8.
- Reset/load: assert i_rst 2 cycles, then LOAD 0xA5 -> o_par_out=0x00, o_cnt=0 during reset; 0xA5, o_cnt=0 one cycle after load.
- Shift/rotate: from 0xA5:
  - SHL, ser_in_l=1 -> 0x4B.
  - SHR, ser_in_r=0 from 0xA5 -> 0x52.
  - ROL -> 0x4B.
  - ROR -> 0xD2.
  - ASR from 0x85 -> 0xC2.
- Frame completion: LOAD 0x81, then 8 SHR with ser_in_r=0 and o_ser_out_r sampled each cycle.
  - Sampled sequence: 1,0,0,0,0,0,0,1.
  - o_done pulses once after the 8th shift; o_cnt=8. A 9th shift keeps o_cnt=8 and o_done=0.
- Enable gating: LOAD 0x3C, then alternate i_en 0/1 with mode SHL.
  - R and o_cnt change only on enabled cycles; o_done arrives after the 8th enabled shift.
- Priority: i_rst=1 with i_en=1, mode LOAD 0xFF -> R=0.
  - CLEAR after 5 shifts -> R=0, o_cnt=0.
  - LOAD on the would-be 8th shift -> no o_done.
- WIDTH=2 build: LOAD 0b10, ROL twice -> 0b01 then 0b10; o_done after the 2nd.
